// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a word-organised DataMemory port.
// Optional MISALIGN_TRAP_EN: reject misaligned, illegal-size and out-of-range requests.
module mem_access_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] word_idx;

  // Little-endian lane pick followed by sign/zero extension; size 10 returns the word.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00:   m[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic err_q, err_d;
  logic req_illegal;

  assign req_illegal = (req_size == 2'b11)
                    || (req_size == 2'b01 && req_addr[0])
                    || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                    || (req_addr >= 32'(MEM_WORDS * 4));
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign word_idx  = {2'b00, addr_q[31:2]};
  assign rsp_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    uns_d     = uns_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
`ifdef MISALIGN_TRAP_EN
    err_d     = err_q;
`endif
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          uns_d   = req_unsigned;
          // Size 11 collapses to a word access; with trapping enabled it errors first.
          size_d  = (req_size == 2'b11) ? 2'b10 : req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          state_d = ACCESS;
`ifdef MISALIGN_TRAP_EN
          err_d   = 1'b0;
          if (req_illegal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      ACCESS: begin
        mem_addr = word_idx;
        if (!we_q) begin
          mem_read = 1'b1;
          rdata_d  = load_extend(mem_rdata, size_q, uns_q, addr_q[1:0]);
          state_d  = RESP;
        end else if (size_q == 2'b10) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
          state_d   = RESP;
        end else begin
          mem_read = 1'b1;
          merge_d  = store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
          state_d  = WRITE;
        end
      end
      WRITE: begin
        mem_addr  = word_idx;
        mem_write = 1'b1;
        mem_wdata = merge_q;
        state_d   = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response state; async reset makes mem_write drop without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Latched request fields; only observed while the FSM is busy, so no reset needed.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    uns_q   <= uns_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    merge_q <= merge_d;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table with scoreboard plus backpressure and reset sequences.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   overlap_cnt = 0;

  mem_access_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (mem_read && mem_write) overlap_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                              input logic ee, input int lat, input int rd, input int wr);
    vec_t v;
    v.name = n; v.we = we; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
  endtask

  task automatic run(input vec_t v);
    int   lat;
    int   guard;
    int   rd0;
    int   wr0;
    exp_t e;
    @(negedge clk);
    drive(v);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({v.name, "_req_ready"}, 32'(req_ready), 32'd1);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, "_rdata"}, rsp_rdata, e.rdata);
    chk({v.name, "_err"}, 32'(rsp_err), 32'(e.err));
    chk({v.name, "_mem_reads"}, 32'(rd_cnt - rd0), 32'(v.exp_rd));
    chk({v.name, "_mem_writes"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
    @(posedge clk);
    #1;
    chk({v.name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int guard;
    vecs.push_back(mk("sw_10",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1));
    vecs.push_back(mk("lw_10",  0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0));
    vecs.push_back(mk("sw_20",  1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0,        0, 2, 0, 1));
    vecs.push_back(mk("sb_21",  1, 2'b00, 0, 32'h21, 32'h000000AA, 32'h0,        0, 3, 1, 1));
    vecs.push_back(mk("lw_20a", 0, 2'b10, 0, 32'h20, 32'h0,        32'h1122AA44, 0, 2, 1, 0));
    vecs.push_back(mk("sw_30",  1, 2'b10, 0, 32'h30, 32'h80FF7F01, 32'h0,        0, 2, 0, 1));
    vecs.push_back(mk("lb_32",  0, 2'b00, 0, 32'h32, 32'h0,        32'hFFFFFFFF, 0, 2, 1, 0));
    vecs.push_back(mk("lbu_32", 0, 2'b00, 1, 32'h32, 32'h0,        32'h000000FF, 0, 2, 1, 0));
    vecs.push_back(mk("lh_32",  0, 2'b01, 0, 32'h32, 32'h0,        32'hFFFF80FF, 0, 2, 1, 0));
    vecs.push_back(mk("lhu_30", 0, 2'b01, 1, 32'h30, 32'h0,        32'h00007F01, 0, 2, 1, 0));
    vecs.push_back(mk("lb_31",  0, 2'b00, 0, 32'h31, 32'h0,        32'h0000007F, 0, 2, 1, 0));
    vecs.push_back(mk("sh_22",  1, 2'b01, 0, 32'h22, 32'hFFFF5566, 32'h0,        0, 3, 1, 1));
    vecs.push_back(mk("lw_20b", 0, 2'b10, 1, 32'h20, 32'h0,        32'h5566AA44, 0, 2, 1, 0));
    vecs.push_back(mk("lh_20",  0, 2'b01, 0, 32'h20, 32'h0,        32'hFFFFAA44, 0, 2, 1, 0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_31_err",  0, 2'b10, 0, 32'h31,  32'h0,    32'h0, 1, 1, 0, 0));
    vecs.push_back(mk("sh_400_err", 1, 2'b01, 0, 32'h400, 32'h1234, 32'h0, 1, 1, 0, 0));
    vecs.push_back(mk("sz3_err",    0, 2'b11, 0, 32'h20,  32'h0,    32'h0, 1, 1, 0, 0));
    vecs.push_back(mk("sh_21_err",  1, 2'b01, 0, 32'h21,  32'h9999, 32'h0, 1, 1, 0, 0));
    vecs.push_back(mk("lw_20_kept", 0, 2'b10, 0, 32'h20,  32'h0,    32'h5566AA44, 0, 2, 1, 0));
`else
    vecs.push_back(mk("lw_31_align", 0, 2'b10, 0, 32'h31, 32'h0, 32'h80FF7F01, 0, 2, 1, 0));
    vecs.push_back(mk("sz3_word",    0, 2'b11, 1, 32'h20, 32'h0, 32'h5566AA44, 0, 2, 1, 0));
    vecs.push_back(mk("lh_33_align", 0, 2'b01, 0, 32'h33, 32'h0, 32'hFFFF80FF, 0, 2, 1, 0));
`endif

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run(vecs[i]);

    // Backpressure: response held for 5 cycles with rsp_ready low
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(mk("bp_lw", 0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 10) begin
      @(posedge clk);
      #1;
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_after_req_ready", 32'(req_ready), 32'd1);
    chk("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset asserted while a byte store is in WRITE
    @(negedge clk);
    drive(mk("rst_sb", 1, 2'b00, 0, 32'h10, 32'h00000055, 32'h0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rstw_access_read", 32'(mem_read), 32'd1);
    @(posedge clk);
    #1;
    chk("rstw_write_active", 32'(mem_write), 32'd1);
    chk("rstw_merged", mem_wdata, 32'hDEADBE55);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_write_drop", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    chk("rstw_mem_kept", mem[4], 32'hDEADBEEF);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstw_req_ready", 32'(req_ready), 32'd1);
    chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    run(mk("lw_10_after_rst", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0));

    chk("rd_wr_exclusive", 32'(overlap_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

endmodule
